logic_pipe_stage_array: RTL and testbench

- Parametrised, clocked successor to the team's three-input gate circuit.
- Computes the bitwise functions d = ~(a & b) | c and e = a & b over WIDTH-bit vectors.
- Models propagation delay as LATENCY register stages, not gate delays.
- Valid/ready handshakes on both sides, bubble-collapsing stalls, and a saturating counter of completed output transfers.

---
 rtl/logic_pipe_stage_array.sv | 108 ++++++++++
 tb/tb_logic_pipe_stage_array.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_stage_array.sv
// Clocked three-input gate: d = ~(a&b)|c, e = a&b, carried through LATENCY
// valid/ready register stages with bubble collapse and a saturating transfer counter.

module logic_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_e,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_d,
  output logic [WIDTH-1:0] o_e
);
  logic             r_vld;
  logic [WIDTH-1:0] r_d, r_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_d   <= '0;
      r_e   <= '0;
    end else if (i_load) begin
      r_vld <= i_vld;
      r_d   <= i_d;
      r_e   <= i_e;
    end
  end

  assign o_vld = r_vld;
  assign o_d   = r_d;
  assign o_e   = r_e;
endmodule

module logic_pipe_stage_array #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic [LATENCY-1:0]            w_vld;
  logic [LATENCY:0]              w_rdy;
  logic [LATENCY-1:0][WIDTH-1:0] w_d, w_e;
  logic [WIDTH-1:0]              w_and;
  logic [CNT_W-1:0]              r_cnt;

  assign w_and = a & b;

  // A stage may advance if it is empty or the stage below it can advance.
  always_comb begin
    w_rdy          = '0;
    w_rdy[LATENCY] = out_ready;
    for (int i = LATENCY - 1; i >= 0; i--)
      w_rdy[i] = ~w_vld[i] | w_rdy[i+1];
  end

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic             w_vin;
    logic [WIDTH-1:0] w_din, w_ein;
    if (gi == 0) begin : g_head
      assign w_vin = in_valid;
      assign w_din = ~w_and | c;
      assign w_ein = w_and;
    end else begin : g_body
      assign w_vin = w_vld[gi-1];
      assign w_din = w_d[gi-1];
      assign w_ein = w_e[gi-1];
    end
    logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_rdy[gi]),
      .i_vld  (w_vin),
      .i_d    (w_din),
      .i_e    (w_ein),
      .o_vld  (w_vld[gi]),
      .o_d    (w_d[gi]),
      .o_e    (w_e[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (out_valid && out_ready && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign in_ready  = w_rdy[0] & ~rst;
  assign out_valid = w_vld[LATENCY-1];
  assign d         = w_d[LATENCY-1];
  assign e         = w_e[LATENCY-1];
  assign xfer_cnt  = r_cnt;
endmodule

// File: tb/tb_logic_pipe_stage_array.sv
// Scoreboard bench for logic_pipe_stage_array (WIDTH=4, LATENCY=3), plus a
// CNT_W=2 twin on the same inputs for counter saturation.

module tb_logic_pipe_stage_array;
  localparam int W   = 4;
  localparam int LAT = 3;

  logic         clk, rst, in_valid, out_ready;
  logic [W-1:0] a, b, c;
  logic         in_ready, out_valid, s_in_ready, s_out_valid;
  logic [W-1:0] d, e, s_d_o, s_e_o;
  logic [7:0]   xfer_cnt;
  logic [1:0]   sat_cnt;

  logic_pipe_stage_array #(.WIDTH(W), .LATENCY(LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .e(e), .xfer_cnt(xfer_cnt));

  logic_pipe_stage_array #(.WIDTH(W), .LATENCY(LAT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .c(c), .out_valid(s_out_valid), .out_ready(out_ready),
    .d(s_d_o), .e(s_e_o), .xfer_cnt(sat_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_chk, n_pass, mcnt;
  logic [7:0] q[$];
  logic       s_ir, s_ov, prev_stall;
  logic [W-1:0] s_d, s_e, pv_d, pv_e;
  logic [7:0] s_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Truth table per bit: {a,b,c}=110 is the only d=0 row; e=1 only for a=b=1.
  function automatic logic [7:0] ref_de(input logic [W-1:0] ia, ib, ic);
    logic [W-1:0] rd, re;
    logic [2:0]   cb;
    for (int k = 0; k < W; k++) begin
      cb    = {ia[k], ib[k], ic[k]};
      re[k] = (cb[2:1] == 2'b11);
      rd[k] = (cb != 3'b110);
    end
    return {rd, re};
  endfunction

  // Observe one cycle at the negedge, update the model, then take the edge.
  task automatic cyc();
    logic [7:0] ex;
    @(negedge clk);
    s_ir = in_ready; s_ov = out_valid; s_d = d; s_e = e; s_cnt = xfer_cnt;
    if (rst) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      q.delete();
      mcnt = 0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {31'd0, in_ready},
          {31'd0, !((q.size() == LAT) && !out_ready)});
      chk("xfer_cnt", {24'd0, xfer_cnt}, mcnt);
      chk("sat_cnt", {30'd0, sat_cnt}, (mcnt > 3) ? 3 : mcnt);
      chk("twin_valid", {30'd0, s_out_valid, s_in_ready}, {30'd0, out_valid, in_ready});
      if (q.size() == 0) chk("spurious_valid", {31'd0, out_valid}, 32'd0);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_de", {24'd0, d, e}, {24'd0, pv_d, pv_e});
      end
      if (in_valid && in_ready) q.push_back(ref_de(a, b, c));
      if (out_valid && out_ready) begin
        ex = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk("out_de", {24'd0, d, e}, {24'd0, ex});
        mcnt++;
      end
      prev_stall = out_valid && !out_ready;
      pv_d = d; pv_e = e;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
    chk("drain_empty", q.size(), 32'd0);
  endtask

  task automatic rnd_abc();
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
  endtask

  int acc, ones, run, maxrun;
  logic [2:0] cb;

  initial begin
    n_chk = 0; n_pass = 0; mcnt = 0; prev_stall = 1'b0;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    rnd_abc();

    // reset with in_valid held high
    cyc(); rnd_abc(); cyc();
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    chk("rst_out", {24'd0, s_ov, s_d, s_e[2:0]}, 32'd0);
    chk("rst_e_cnt", {23'd0, s_e[3], s_cnt}, 32'd0);

    // single vector, fixed latency, one cycle of valid
    for (int t = 0; t < 2; t++) begin
      a = 4'b0011; b = 4'b0101; c = (t == 0) ? 4'b0001 : 4'b0000;
      in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      chk("single_acc", {31'd0, s_ir}, 32'd1);
      in_valid = 1'b0;
      cyc(); chk("lat_n0", {31'd0, s_ov}, 32'd0);
      cyc(); chk("lat_n1", {31'd0, s_ov}, 32'd0);
      cyc(); chk("lat_n2", {31'd0, s_ov}, 32'd1);
      chk("single_de", {24'd0, s_d, s_e}, (t == 0) ? 32'h0000_00F1 : 32'h0000_00E1);
      cyc(); chk("single_once", {31'd0, s_ov}, 32'd0);
    end

    // streaming: every (a,b,c) combination on every bit position
    do_reset();
    ones = 0; run = 0; maxrun = 0;
    for (int j = 0; j < 14; j++) begin
      in_valid = (j < 8);
      for (int k = 0; k < W; k++) begin
        cb = 3'((j + k) % 8);
        a[k] = cb[2]; b[k] = cb[1]; c[k] = cb[0];
      end
      cyc();
      if (s_ov) begin ones++; run++; if (run > maxrun) maxrun = run; end
      else run = 0;
    end
    cyc();
    chk("stream_count", ones, 32'd8);
    chk("stream_run", maxrun, 32'd8);
    chk("stream_cnt", {24'd0, s_cnt}, 32'd8);

    // backpressure: fill to capacity, then release
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; rnd_abc(); acc = 0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (s_ir) begin acc++; rnd_abc(); end
    end
    chk("bp_accepts", acc, 32'd3);
    chk("bp_full", {31'd0, s_ir}, 32'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    cyc();
    chk("bp_ready_on_drain", {30'd0, s_ov, s_ir}, 32'd3);
    drain();
    chk("bp_drained", mcnt, 32'd3);

    // bubble collapse behind a stalled head
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; rnd_abc();
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    out_ready = 1'b0; in_valid = 1'b1; rnd_abc();
    cyc(); chk("bub_acc1", {31'd0, s_ir}, 32'd1);
    rnd_abc();
    cyc(); chk("bub_acc2", {31'd0, s_ir}, 32'd1);
    cyc(); chk("bub_full", {30'd0, s_ov, s_ir}, 32'd2);
    drain();

    // reset with vectors in flight
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    rnd_abc(); cyc(); rnd_abc(); cyc();
    rst = 1'b1; rnd_abc();
    cyc();
    rst = 1'b0; in_valid = 1'b0; ones = 0;
    for (int j = 0; j < 5; j++) begin
      cyc();
      if (j == 0) chk("rst_ready_back", {31'd0, s_ir}, 32'd1);
      if (s_ov) ones++;
    end
    chk("rst_flush", ones, 32'd0);
    chk("rst_flush_cnt", {24'd0, s_cnt}, 32'd0);

    // saturation on the CNT_W=2 twin
    in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin rnd_abc(); cyc(); end
    drain();
    cyc(); cyc(); cyc();
    chk("sat_main", {24'd0, xfer_cnt}, 32'd5);
    chk("sat_hold", {30'd0, sat_cnt}, 32'd3);

    // random traffic with random backpressure; source holds until accepted
    do_reset();
    in_valid = 1'b0;
    for (int j = 0; j < 300; j++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!(in_valid && !s_ir)) begin
        in_valid = $urandom_range(0, 1);
        rnd_abc();
      end
      cyc();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
